// File: rtl/nerv_mem_pkg.sv
// Shared types, widths and helpers for the nerv data-memory responder.
package nerv_mem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;
    typedef logic [6:0]  width_t;

    localparam width_t WIDTH_B = 7'd8;
    localparam width_t WIDTH_H = 7'd16;
    localparam width_t WIDTH_W = 7'd32;

    // Access width implied by a strobe pattern. Full word and reads (no strobes)
    // report 32, aligned halves report 16, everything else is treated as a byte.
    function automatic width_t strb_to_width(input strb_t strb);
        width_t w;
        case (strb)
            4'b1111, 4'b0000: w = WIDTH_W;
            4'b0011, 4'b1100: w = WIDTH_H;
            default:          w = WIDTH_B;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/nerv_stall_lfsr.sv
// Pseudo-random back-pressure generator: a free-running 16-bit Galois LFSR
// decides when to stall, and a run counter bounds consecutive stall cycles.
// THRESH may be 0..16; MAX_STALL must fit in 8 bits.
module nerv_stall_lfsr #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          THRESH    = 4,
    parameter int          MAX_STALL = 7
) (
    input  logic clock,
    input  logic reset_n,
    input  logic stall_en,
    output logic stall
);

    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [4:0]  THRESH_V = 5'(THRESH);
    localparam logic [7:0]  MAX_V    = 8'(MAX_STALL);

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [7:0]  stall_cnt;
    logic [7:0]  stall_cnt_next;
    logic        stall_next;

    // stall_cnt holds how many consecutive cycles stall has been high (including
    // the current one), so comparing it against MAX_STALL caps each run exactly.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
        stall_next = stall_en
                  && ({1'b0, lfsr[3:0]} < THRESH_V)
                  && (stall_cnt < MAX_V);
        stall_cnt_next = 8'd0;
        if (stall_next) begin
            stall_cnt_next = (stall_cnt == MAX_V) ? stall_cnt : stall_cnt + 8'd1;
        end
    end

    // LFSR advances every cycle out of reset, independent of stall_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr      <= SEED;
            stall_cnt <= 8'd0;
            stall     <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            stall_cnt <= stall_cnt_next;
            stall     <= stall_next;
        end
    end

endmodule

// File: rtl/nerv_dmem_responder.sv
// Target end of the nerv dmem request interface: byte-strobed word memory with
// registered read data, bounded pseudo-random stall, one-cycle access trace and
// read/write counters.
// Optional feature macro: NERV_DMEM_FAULT_EN adds the dmem_fault port and turns
// out-of-range accesses into faults instead of wrapping modulo DEPTH_WORDS.
module nerv_dmem_responder
    import nerv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [15:0] STALL_SEED   = 16'hACE1,
    parameter int          STALL_THRESH = 4,
    parameter int          MAX_STALL    = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall_en,
    output logic        stall,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
`ifdef NERV_DMEM_FAULT_EN
    output logic        dmem_fault,
`endif
    output logic        trace_valid,
    output logic        trace_write,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [6:0]  trace_width,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef NERV_DMEM_FAULT_EN
    localparam word_t SPAN_BYTES = word_t'(DEPTH_WORDS * 4);
`endif

    word_t             mem [DEPTH_WORDS];
    word_t             offset;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              is_write;
    logic              in_range;
    word_t             read_word;

    nerv_stall_lfsr #(
        .SEED      (STALL_SEED),
        .THRESH    (STALL_THRESH),
        .MAX_STALL (MAX_STALL)
    ) u_stall (
        .clock    (clock),
        .reset_n  (reset_n),
        .stall_en (stall_en),
        .stall    (stall)
    );

    // Address decode and accept qualification; the low two address bits never
    // reach the index, and the truncating cast gives the modulo-depth wrap.
    always_comb begin
        offset   = dmem_addr - BASE_ADDR;
        idx      = IDX_W'(offset >> 2);
        accept   = dmem_valid && !stall;
        is_write = |dmem_wstrb;
`ifdef NERV_DMEM_FAULT_EN
        in_range = (dmem_addr >= BASE_ADDR) && (offset < SPAN_BYTES);
`else
        in_range = 1'b1;
`endif
        read_word = in_range ? mem[idx] : '0;
    end

    // Byte-lane writes on the accept edge; the array has no reset, and writes are
    // held off while reset is asserted so an aborted access leaves no trace.
    always_ff @(posedge clock) begin
        if (reset_n && accept && is_write && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register and access counters; rdata only moves on a read accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dmem_rdata <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else if (accept) begin
            if (is_write) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                dmem_rdata <= read_word;
                rd_count   <= rd_count + 32'd1;
            end
        end
    end

    // One-cycle trace record of the access accepted at the previous edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trace_valid <= 1'b0;
            trace_write <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
            trace_width <= '0;
        end else begin
            trace_valid <= accept;
            trace_write <= accept && is_write;
            trace_addr  <= accept ? dmem_addr : '0;
            trace_data  <= '0;
            trace_width <= '0;
            if (accept) begin
                trace_data  <= is_write ? dmem_wdata : read_word;
                trace_width <= strb_to_width(dmem_wstrb);
            end
        end
    end

`ifdef NERV_DMEM_FAULT_EN
    // Fault flag pulses for exactly the cycle after an out-of-range accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dmem_fault <= 1'b0;
        end else begin
            dmem_fault <= accept && !in_range;
        end
    end
`endif

endmodule

// File: tb/tb_nerv_dmem_responder.sv
// Self-checking bench for nerv_dmem_responder: directed vector table, hand-written
// stall/reset sequences on a THRESH=16 instance, and randomized traffic against a
// behavioural model. Honors NERV_DMEM_FAULT_EN when defined.
module tb_nerv_dmem_responder;

    localparam int DEPTH  = 1024;
    localparam int THRESH = 4;
    localparam int MAXS   = 7;
`ifdef NERV_DMEM_FAULT_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_en = 1'b0;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_wdata = '0;
    logic        stall_en2 = 1'b0;
    logic        valid2 = 1'b0;

    logic        stall, trace_valid, trace_write;
    logic [31:0] dmem_rdata, trace_addr, trace_data, rd_count, wr_count;
    logic [6:0]  trace_width;
    logic        stall2, trace_valid2, trace_write2;
    logic [31:0] rdata2, trace_addr2, trace_data2, rd_count2, wr_count2;
    logic [6:0]  trace_width2;
`ifdef NERV_DMEM_FAULT_EN
    logic        dmem_fault, fault2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nerv_dmem_responder #(.DEPTH_WORDS(DEPTH), .STALL_THRESH(THRESH), .MAX_STALL(MAXS)) dut (
        .clock(clock), .reset_n(reset_n), .stall_en(stall_en), .stall(stall),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
`ifdef NERV_DMEM_FAULT_EN
        .dmem_fault(dmem_fault),
`endif
        .trace_valid(trace_valid), .trace_write(trace_write), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_width(trace_width),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    nerv_dmem_responder #(.DEPTH_WORDS(DEPTH), .STALL_THRESH(16), .MAX_STALL(MAXS)) dut16 (
        .clock(clock), .reset_n(reset_n), .stall_en(stall_en2), .stall(stall2),
        .dmem_valid(valid2), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(rdata2),
`ifdef NERV_DMEM_FAULT_EN
        .dmem_fault(fault2),
`endif
        .trace_valid(trace_valid2), .trace_write(trace_write2), .trace_addr(trace_addr2),
        .trace_data(trace_data2), .trace_width(trace_width2),
        .rd_count(rd_count2), .wr_count(wr_count2)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [15:0] m_lfsr;
    int          m_run;
    logic        m_stall;
    logic        m_acc;
    logic [31:0] e_rdata, e_taddr, e_tdata, e_rd, e_wr;
    logic        e_tv, e_tw, e_fault;
    logic [6:0]  e_width;

    function automatic logic [6:0] widthOf(input logic [3:0] s);
        if (s == 4'b0000 || $countones(s) == 4) return 7'd32;
        if (s == 4'b0011 || s == 4'b1100) return 7'd16;
        return 7'd8;
    endfunction

    task automatic modelReset();
        m_lfsr = 16'hACE1; m_run = 0; m_stall = 1'b0; m_acc = 1'b0;
        e_rdata = '0; e_taddr = '0; e_tdata = '0; e_rd = '0; e_wr = '0;
        e_tv = 1'b0; e_tw = 1'b0; e_fault = 1'b0; e_width = '0;
    endtask

    task automatic modelStep();
        logic [31:0] off;
        int          idx;
        logic        flt;
        logic        nxt;
        m_acc = dmem_valid && !m_stall;
        e_tv = 1'b0; e_tw = 1'b0; e_fault = 1'b0;
        if (m_acc) begin
            off = dmem_addr;
            idx = int'((off / 4) % DEPTH);
            flt = FAULT_BUILD && (off >= DEPTH * 4);
            e_tv = 1'b1; e_taddr = dmem_addr; e_fault = flt;
            if (dmem_wstrb != 4'b0000) begin
                e_wr = e_wr + 1; e_tw = 1'b1; e_tdata = dmem_wdata; e_width = widthOf(dmem_wstrb);
                if (!flt) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_wstrb[b]) m_mem[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
                end
            end else begin
                e_rd = e_rd + 1;
                e_rdata = flt ? 32'h0 : m_mem[idx];
                e_tdata = e_rdata; e_width = 7'd32;
            end
        end
        nxt = stall_en && (int'(m_lfsr % 16) < THRESH) && (m_run < MAXS);
        m_run = nxt ? m_run + 1 : 0;
        m_stall = nxt;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        dmem_valid = v; dmem_addr = a; dmem_wstrb = s; dmem_wdata = d;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        modelStep();
        #1;
        checkOutput("stall", {31'b0, stall}, {31'b0, m_stall});
        checkOutput("rdata", dmem_rdata, e_rdata);
        checkOutput("trace_valid", {31'b0, trace_valid}, {31'b0, e_tv});
        checkOutput("rd_count", rd_count, e_rd);
        checkOutput("wr_count", wr_count, e_wr);
        if (e_tv) begin
            checkOutput("trace_write", {31'b0, trace_write}, {31'b0, e_tw});
            checkOutput("trace_addr", trace_addr, e_taddr);
            checkOutput("trace_data", trace_data, e_tdata);
            checkOutput("trace_width", {25'b0, trace_width}, {25'b0, e_width});
        end
`ifdef NERV_DMEM_FAULT_EN
        checkOutput("fault", {31'b0, dmem_fault}, {31'b0, e_fault});
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [6:0]  exp_width;
        logic        exp_fault;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mkVec(input logic v, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] d, input logic [31:0] r,
                                   input logic [6:0] w, input logic f);
        vec_t t;
        t.valid = v; t.addr = a; t.wstrb = s; t.wdata = d;
        t.exp_rdata = r; t.exp_width = w; t.exp_fault = f;
        return t;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int exp_rd;
        int exp_wr;
        logic [31:0] a;

        vecs[0]  = mkVec(1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h00000000, 7'd32, 0);
        vecs[1]  = mkVec(1, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF, 7'd32, 0);
        vecs[2]  = mkVec(1, 32'h20,   4'hF, 32'h11223344, 32'hDEADBEEF, 7'd32, 0);
        vecs[3]  = mkVec(1, 32'h20,   4'h2, 32'h0000AA00, 32'hDEADBEEF, 7'd8,  0);
        vecs[4]  = mkVec(1, 32'h20,   4'h0, 32'h0,        32'h1122AA44, 7'd32, 0);
        vecs[5]  = mkVec(1, 32'h24,   4'hC, 32'hABCD0000, 32'h1122AA44, 7'd16, 0);
        vecs[6]  = mkVec(1, 32'h24,   4'h3, 32'h00001234, 32'h1122AA44, 7'd16, 0);
        vecs[7]  = mkVec(1, 32'h27,   4'h0, 32'h0,        32'hABCD1234, 7'd32, 0);
        vecs[8]  = mkVec(1, 32'h28,   4'hF, 32'h00000000, 32'hABCD1234, 7'd32, 0);
        vecs[9]  = mkVec(1, 32'h28,   4'h5, 32'hFFFFFFFF, 32'hABCD1234, 7'd8,  0);
        vecs[10] = mkVec(1, 32'h28,   4'h0, 32'h0,        32'h00FF00FF, 7'd32, 0);
        vecs[11] = mkVec(1, 32'h2C,   4'hF, 32'h12345678, 32'h00FF00FF, 7'd32, 0);
        vecs[12] = mkVec(1, 32'h2C,   4'h8, 32'h77000000, 32'h00FF00FF, 7'd8,  0);
        vecs[13] = mkVec(1, 32'h2C,   4'h0, 32'h0,        32'h77345678, 7'd32, 0);
        vecs[14] = mkVec(0, 32'h2C,   4'h0, 32'h0,        32'h77345678, 7'd0,  0);
        vecs[15] = mkVec(1, 32'h00,   4'hF, 32'h01020304, 32'h77345678, 7'd32, 0);
        vecs[16] = mkVec(1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h77345678, 7'd32, FAULT_BUILD);
        vecs[17] = mkVec(1, 32'h00,   4'h0, 32'h0,
                         FAULT_BUILD ? 32'h01020304 : 32'hFFFFFFFF, 7'd32, 0);
        vecs[18] = mkVec(1, 32'h1000, 4'h0, 32'h0,
                         FAULT_BUILD ? 32'h00000000 : 32'hFFFFFFFF, 7'd32, FAULT_BUILD);
        vecs[19] = mkVec(0, 32'h0,    4'h0, 32'h0,
                         FAULT_BUILD ? 32'h00000000 : 32'hFFFFFFFF, 7'd0,  0);
        vecs[20] = mkVec(1, 32'h10,   4'h6, 32'h00BBCC00,
                         FAULT_BUILD ? 32'h00000000 : 32'hFFFFFFFF, 7'd8,  0);
        vecs[21] = mkVec(1, 32'h10,   4'h0, 32'h0,        32'hDEBBCCEF, 7'd32, 0);

        // reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_stall", {31'b0, stall}, 32'h0);
        checkOutput("reset_rdata", dmem_rdata, 32'h0);
        checkOutput("reset_trace_valid", {31'b0, trace_valid}, 32'h0);
        checkOutput("reset_trace_data", trace_data, 32'h0);
        checkOutput("reset_rd_count", rd_count, 32'h0);
        checkOutput("reset_wr_count", wr_count, 32'h0);
        checkOutput("reset_stall16", {31'b0, stall2}, 32'h0);
        reset_n = 1'b1;
        modelReset();

        // directed table
        exp_rd = 0; exp_wr = 0;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata);
            stepCycle();
            if (vecs[i].valid) begin
                if (vecs[i].wstrb != 4'h0) exp_wr++; else exp_rd++;
            end
            checkOutput($sformatf("vec%0d_rdata", i), dmem_rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_trace_valid", i), {31'b0, trace_valid}, {31'b0, vecs[i].valid});
            if (vecs[i].valid) begin
                checkOutput($sformatf("vec%0d_width", i), {25'b0, trace_width}, {25'b0, vecs[i].exp_width});
                checkOutput($sformatf("vec%0d_trace_data", i), trace_data,
                            (vecs[i].wstrb != 4'h0) ? vecs[i].wdata : vecs[i].exp_rdata);
            end
`ifdef NERV_DMEM_FAULT_EN
            checkOutput($sformatf("vec%0d_fault", i), {31'b0, dmem_fault}, {31'b0, vecs[i].exp_fault});
`endif
        end
        checkOutput("table_rd_count", rd_count, 32'(exp_rd));
        checkOutput("table_wr_count", wr_count, 32'(exp_wr));
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);

        // always-stall instance: bounded runs, held read accepted once
        applyStimulus(1'b0, 32'h10, 4'hF, 32'hCAFEF00D);
        valid2 = 1'b1; stall_en2 = 1'b0;
        stepCycle();
        checkOutput("s16_wr_count", wr_count2, 32'd1);
        valid2 = 1'b0; stall_en2 = 1'b1;
        for (int i = 1; i <= MAXS; i++) begin
            stepCycle();
            checkOutput($sformatf("s16_stall_high%0d", i), {31'b0, stall2}, 32'h1);
            checkOutput($sformatf("s16_no_trace%0d", i), {31'b0, trace_valid2}, 32'h0);
            if (i == 1) begin
                applyStimulus(1'b0, 32'h12, 4'h0, 32'h0);
                valid2 = 1'b1;
            end
        end
        stepCycle();
        checkOutput("s16_stall_gap", {31'b0, stall2}, 32'h0);
        checkOutput("s16_gap_no_trace", {31'b0, trace_valid2}, 32'h0);
        checkOutput("s16_gap_rd_count", rd_count2, 32'h0);
        stepCycle();
        checkOutput("s16_stall_again", {31'b0, stall2}, 32'h1);
        checkOutput("s16_read_trace", {31'b0, trace_valid2}, 32'h1);
        checkOutput("s16_read_rdata", rdata2, 32'hCAFEF00D);
        checkOutput("s16_read_count", rd_count2, 32'h1);
        checkOutput("s16_read_addr", trace_addr2, 32'h12);
        checkOutput("s16_read_width", {25'b0, trace_width2}, 32'd32);
        valid2 = 1'b0;
        stepCycle();
        checkOutput("s16_single_pulse", {31'b0, trace_valid2}, 32'h0);
        checkOutput("s16_count_once", rd_count2, 32'h1);
        checkOutput("s16_rdata_held", rdata2, 32'hCAFEF00D);
        checkOutput("s16_still_stalled", {31'b0, stall2}, 32'h1);
        valid2 = 1'b1; stall_en2 = 1'b0;
        stepCycle();
        checkOutput("s16_en_drop_stall", {31'b0, stall2}, 32'h0);
        checkOutput("s16_en_drop_no_trace", {31'b0, trace_valid2}, 32'h0);
        stepCycle();
        checkOutput("s16_pending_accepted", {31'b0, trace_valid2}, 32'h1);
        checkOutput("s16_pending_count", rd_count2, 32'h2);

        // asynchronous reset in the middle of a stalled, pending access
        valid2 = 1'b0; stall_en2 = 1'b1;
        stepCycle();
        checkOutput("s16_restall", {31'b0, stall2}, 32'h1);
        valid2 = 1'b1;
        stepCycle();
        checkOutput("s16_pending_stalled", {31'b0, trace_valid2}, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_stall16", {31'b0, stall2}, 32'h0);
        checkOutput("rst_mid_rd_count16", rd_count2, 32'h0);
        checkOutput("rst_mid_wr_count16", wr_count2, 32'h0);
        checkOutput("rst_mid_rdata16", rdata2, 32'h0);
        checkOutput("rst_mid_rd_count", rd_count, 32'h0);
        checkOutput("rst_mid_wr_count", wr_count, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_hold_rd_count16", rd_count2, 32'h0);
        checkOutput("rst_hold_trace16", {31'b0, trace_valid2}, 32'h0);
        valid2 = 1'b0; stall_en2 = 1'b0;
        reset_n = 1'b1;
        modelReset();

        // randomized traffic against the model, from a fresh LFSR seed
        stall_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 4'hF, $urandom());
            stepCycle();
        end
        stall_en = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) stall_en = !stall_en;
            if (!(dmem_valid && !m_acc)) begin
                a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3) << 12);
                applyStimulus(($urandom_range(0, 9) < 7), a,
                              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                              $urandom());
            end
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
